ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist_if.sv | 29 ++
 rtl/ram_bist.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ram_bist.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_if.sv
// RAM-side bus of the march-style BIST engine.
// The BIST drives address, write data and the strobes; the RAM answers on
// data_out one cycle after a read address is presented.
interface ram_bist_if #(
   parameter int AW = 3,
   parameter int DW = 8
);
   logic [AW-1:0] address;
   logic [DW-1:0] data_in;
   logic          write;
   logic          select;
   logic [DW-1:0] data_out;

   modport master (
      output address,
      output data_in,
      output write,
      output select,
      input  data_out
   );

   modport slave (
      input  address,
      input  data_in,
      input  write,
      input  select,
      output data_out
   );
endinterface

// File: rtl/ram_bist.sv
// ram_bist: four-phase RAM self test.
//   WR_PAT  ascending writes of PATTERN
//   RD_PAT  ascending reads checked against PATTERN, plus one drain cycle
//   WR_INV  descending writes of ~PATTERN
//   RD_INV  descending reads checked against ~PATTERN, plus one drain cycle
// Read data returns one cycle after its address, so the address and the
// expected word of each read are carried in a one-stage compare pipeline.
// Every output is a flop; the combinational blocks only compute next values.
module ram_bist #(
   parameter int            AW      = 3,
   parameter int            DW      = 8,
   parameter logic [DW-1:0] PATTERN = 8'h55
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [3:0]    err_count,
   output logic [AW-1:0] fail_addr,
   output logic [DW-1:0] fail_data,
   ram_bist_if.master    ram
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_PAT = 3'd1,
      RD_PAT = 3'd2,
      WR_INV = 3'd3,
      RD_INV = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [AW-1:0] ADDR_MIN = {AW{1'b0}};
   localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};
   localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] INV_PAT  = ~PATTERN;
   localparam logic [DW-1:0] DATA_0   = {DW{1'b0}};
   localparam logic [3:0]    ERR_MAX  = 4'd15;

   // state and registered outputs
   state_t        state_r,     state_s;
   logic [AW-1:0] addr_r,      addr_s;
   logic [DW-1:0] data_in_r,   data_in_s;
   logic          write_r,     write_s;
   logic          select_r,    select_s;
   logic          busy_r,      busy_s;
   logic          done_r,      done_s;
   logic          pass_r,      pass_s;
   logic [3:0]    err_r,       err_s;
   logic [AW-1:0] fail_addr_r, fail_addr_s;
   logic [DW-1:0] fail_data_r, fail_data_s;

   // drain flag: set for the idle cycle that follows the last read address
   logic          drain_r,     drain_s;

   // compare pipeline: describes the read whose data is on data_out now
   logic          cmp_vld_r,   cmp_vld_s;
   logic [AW-1:0] cmp_addr_r,  cmp_addr_s;
   logic [DW-1:0] cmp_exp_r,   cmp_exp_s;

   // result of this cycle's compare folded into the error bookkeeping
   logic          mismatch_s;
   logic [3:0]    err_upd_s;
   logic [AW-1:0] fail_addr_upd_s;
   logic [DW-1:0] fail_data_upd_s;

   assign busy        = busy_r;
   assign done        = done_r;
   assign pass        = pass_r;
   assign err_count   = err_r;
   assign fail_addr   = fail_addr_r;
   assign fail_data   = fail_data_r;
   assign ram.address = addr_r;
   assign ram.data_in = data_in_r;
   assign ram.write   = write_r;
   assign ram.select  = select_r;

   // Detect a mismatch on the read data returned this cycle.
   always_comb begin
      mismatch_s = 1'b0;
      if (cmp_vld_r) begin
         mismatch_s = (ram.data_out != cmp_exp_r);
      end else begin
         mismatch_s = 1'b0;
      end
   end

   // Saturating error count; capture address/data only on the first mismatch.
   always_comb begin
      err_upd_s       = err_r;
      fail_addr_upd_s = fail_addr_r;
      fail_data_upd_s = fail_data_r;
      if (mismatch_s) begin
         if (err_r != ERR_MAX) begin
            err_upd_s = err_r + 4'd1;
         end else begin
            err_upd_s = err_r;
         end
         if (err_r == 4'd0) begin
            fail_addr_upd_s = cmp_addr_r;
            fail_data_upd_s = ram.data_out;
         end else begin
            fail_addr_upd_s = fail_addr_r;
            fail_data_upd_s = fail_data_r;
         end
      end else begin
         err_upd_s       = err_r;
         fail_addr_upd_s = fail_addr_r;
         fail_data_upd_s = fail_data_r;
      end
   end

   // Next-state and next-output logic; strobes default low each cycle.
   always_comb begin
      state_s     = state_r;
      addr_s      = addr_r;
      data_in_s   = DATA_0;
      write_s     = 1'b0;
      select_s    = 1'b0;
      busy_s      = busy_r;
      done_s      = 1'b0;
      pass_s      = pass_r;
      err_s       = err_upd_s;
      fail_addr_s = fail_addr_upd_s;
      fail_data_s = fail_data_upd_s;
      drain_s     = 1'b0;
      cmp_vld_s   = 1'b0;
      cmp_addr_s  = cmp_addr_r;
      cmp_exp_s   = cmp_exp_r;

      case (state_r)
         IDLE: begin
            busy_s = 1'b0;
            if (start) begin
               state_s     = WR_PAT;
               addr_s      = ADDR_MIN;
               busy_s      = 1'b1;
               write_s     = 1'b1;
               select_s    = 1'b1;
               data_in_s   = PATTERN;
               err_s       = 4'd0;
               fail_addr_s = ADDR_MIN;
               fail_data_s = DATA_0;
            end else begin
               state_s = IDLE;
            end
         end

         WR_PAT: begin
            if (addr_r == ADDR_MAX) begin
               state_s  = RD_PAT;
               addr_s   = ADDR_MIN;
               select_s = 1'b1;
            end else begin
               addr_s    = addr_r + ADDR_ONE;
               write_s   = 1'b1;
               select_s  = 1'b1;
               data_in_s = PATTERN;
            end
         end

         RD_PAT: begin
            if (drain_r) begin
               state_s   = WR_INV;
               addr_s    = ADDR_MAX;
               write_s   = 1'b1;
               select_s  = 1'b1;
               data_in_s = INV_PAT;
            end else begin
               cmp_vld_s  = 1'b1;
               cmp_addr_s = addr_r;
               cmp_exp_s  = PATTERN;
               if (addr_r == ADDR_MAX) begin
                  drain_s = 1'b1;
               end else begin
                  addr_s   = addr_r + ADDR_ONE;
                  select_s = 1'b1;
               end
            end
         end

         WR_INV: begin
            if (addr_r == ADDR_MIN) begin
               state_s  = RD_INV;
               addr_s   = ADDR_MAX;
               select_s = 1'b1;
            end else begin
               addr_s    = addr_r - ADDR_ONE;
               write_s   = 1'b1;
               select_s  = 1'b1;
               data_in_s = INV_PAT;
            end
         end

         RD_INV: begin
            if (drain_r) begin
               // the last compare lands on this edge, so pass uses the updated count
               state_s = DONE;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               pass_s  = (err_upd_s == 4'd0);
            end else begin
               cmp_vld_s  = 1'b1;
               cmp_addr_s = addr_r;
               cmp_exp_s  = INV_PAT;
               if (addr_r == ADDR_MIN) begin
                  drain_s = 1'b1;
               end else begin
                  addr_s   = addr_r - ADDR_ONE;
                  select_s = 1'b1;
               end
            end
         end

         DONE: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end

         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= IDLE;
         addr_r      <= ADDR_MIN;
         data_in_r   <= DATA_0;
         write_r     <= 1'b0;
         select_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         err_r       <= 4'd0;
         fail_addr_r <= ADDR_MIN;
         fail_data_r <= DATA_0;
         drain_r     <= 1'b0;
         cmp_vld_r   <= 1'b0;
         cmp_addr_r  <= ADDR_MIN;
         cmp_exp_r   <= DATA_0;
      end else begin
         state_r     <= state_s;
         addr_r      <= addr_s;
         data_in_r   <= data_in_s;
         write_r     <= write_s;
         select_r    <= select_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         pass_r      <= pass_s;
         err_r       <= err_s;
         fail_addr_r <= fail_addr_s;
         fail_data_r <= fail_data_s;
         drain_r     <= drain_s;
         cmp_vld_r   <= cmp_vld_s;
         cmp_addr_r  <= cmp_addr_s;
         cmp_exp_r   <= cmp_exp_s;
      end
   end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: an 8x8 RAM with injectable read faults, a run-level
// result model and a per-cycle bus trace expectation.
module tb_ram_bist;
   localparam int         AW  = 3;
   localparam int         DW  = 8;
   localparam logic [7:0] PAT = 8'h55;
   localparam logic [7:0] INV = 8'hAA;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_count;
   logic [2:0] fail_addr;
   logic [7:0] fail_data;

   int checks   = 0;
   int failures = 0;

   ram_bist_if #(.AW(AW), .DW(DW)) ram_bus ();

   ram_bist #(.AW(AW), .DW(DW), .PATTERN(PAT)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_addr (fail_addr),
      .fail_data (fail_data),
      .ram       (ram_bus)
   );

   always #5 clock = ~clock;

   // fault configuration: 0 = good, 1 = stuck bit at one address, 2 = constant data_out
   int         fault_mode = 0;
   logic [2:0] f_addr     = 3'd0;
   int         f_bit      = 0;
   logic       f_val      = 1'b0;
   logic [7:0] f_const    = 8'h00;
   logic [7:0] mem [8];

   function automatic logic [7:0] corrupt(input logic [2:0] a, input logic [7:0] d);
      logic [7:0] r;
      r = d;
      if (fault_mode == 1 && a == f_addr) r[f_bit] = f_val;
      else if (fault_mode == 2) r = f_const;
      return r;
   endfunction

   // RAM model: synchronous write, registered read one cycle after the address
   always @(posedge clock) begin
      if (ram_bus.select) begin
         if (ram_bus.write) mem[ram_bus.address] <= ram_bus.data_in;
         else ram_bus.data_out <= corrupt(ram_bus.address, mem[ram_bus.address]);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected run result: march the read sequence, apply the fault, count misses.
   task automatic model_run(output logic [3:0] e_err, output logic [2:0] e_fa,
                            output logic [7:0] e_fd, output logic e_pass);
      int         n;
      logic [2:0] a;
      logic [7:0] exp_w;
      logic [7:0] got;
      n = 0; e_fa = 3'd0; e_fd = 8'h00;
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 8; i++) begin
            a     = (ph == 0) ? 3'(i) : 3'(7 - i);
            exp_w = (ph == 0) ? PAT : INV;
            got   = corrupt(a, exp_w);
            if (got != exp_w) begin
               if (n == 0) begin e_fa = a; e_fd = got; end
               n++;
            end
         end
      end
      e_err  = (n > 15) ? 4'd15 : 4'(n);
      e_pass = (n == 0);
   endtask

   // Bus activity expected in cycle c (0 = first cycle after start acceptance).
   task automatic trace_exp(input int c, output logic w, output logic s,
                            output logic [7:0] d, output logic [2:0] a, output logic drain);
      w = 1'b0; s = 1'b0; d = 8'h00; a = 3'd0; drain = 1'b0;
      if (c < 8)       begin w = 1'b1; s = 1'b1; d = PAT; a = 3'(c); end
      else if (c < 16) begin s = 1'b1; a = 3'(c - 8); end
      else if (c == 16) drain = 1'b1;
      else if (c < 25) begin w = 1'b1; s = 1'b1; d = INV; a = 3'(7 - (c - 17)); end
      else if (c < 33) begin s = 1'b1; a = 3'(7 - (c - 25)); end
      else drain = 1'b1;
   endtask

   // One full run from a start pulse, checking bus trace, busy span and results.
   task automatic run_check(input string name, input bit repulse, input bit start_in_done);
      logic [3:0] e_err;
      logic [2:0] e_fa;
      logic [7:0] e_fd;
      logic       e_pass;
      logic       w, s, drain;
      logic [7:0] d;
      logic [2:0] a;
      int         bad_trace = 0;
      int         busy_cnt  = 0;
      int         done_cnt  = 0;
      model_run(e_err, e_fa, e_fd, e_pass);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int c = 0; c < 34; c++) begin
         trace_exp(c, w, s, d, a, drain);
         if ({ram_bus.write, ram_bus.select, ram_bus.data_in} !== {w, s, d}) bad_trace++;
         if (!drain && ram_bus.address !== a) bad_trace++;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) done_cnt++;
         if (c < 3) check($sformatf("%s_bus_c%0d", name, c),
                          {ram_bus.write, ram_bus.select, ram_bus.data_in, ram_bus.address},
                          {w, s, d, a});
         start = (repulse && (c == 5 || c == 20)) ? 1'b1 : 1'b0;
         @(negedge clock);
      end
      start = 1'b0;
      check({name, "_trace_errs"}, bad_trace, 0);
      check({name, "_busy_cycles"}, busy_cnt, 34);
      check({name, "_done_in_run"}, done_cnt, 0);
      check({name, "_done_pulse"}, {done, busy, ram_bus.select, ram_bus.write}, 4'b1000);
      check({name, "_pass"}, pass, e_pass);
      check({name, "_err_count"}, err_count, e_err);
      check({name, "_fail_addr"}, fail_addr, e_fa);
      check({name, "_fail_data"}, fail_data, e_fd);
      start = start_in_done;
      @(negedge clock);
      start = 1'b0;
      check({name, "_after_done"}, {done, busy, ram_bus.select}, 3'b000);
      repeat (3) @(negedge clock);
      check({name, "_hold"}, {busy, pass, err_count, fail_addr, fail_data},
            {1'b0, e_pass, e_err, e_fa, e_fd});
   endtask

   initial begin
      int done_seen;
      int busy_seen;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("reset_status", {busy, done, pass, err_count, fail_addr, fail_data}, 0);
      check("reset_bus", {ram_bus.address, ram_bus.data_in, ram_bus.write, ram_bus.select}, 0);

      // clean RAM
      fault_mode = 0;
      run_check("good", 1'b0, 1'b0);

      // bit 0 stuck at 1 on address 5: only the inverse read fails
      fault_mode = 1; f_addr = 3'd5; f_bit = 0; f_val = 1'b1;
      run_check("stuck5", 1'b0, 1'b0);
      check("stuck5_literal", {err_count, fail_addr, fail_data, pass}, {4'd1, 3'd5, 8'hAB, 1'b0});

      // data_out stuck at zero: sixteen misses saturate the counter
      fault_mode = 2; f_const = 8'h00;
      run_check("allzero", 1'b0, 1'b0);
      check("allzero_literal", {err_count, fail_addr, fail_data, pass}, {4'd15, 3'd0, 8'h00, 1'b0});

      // reset in the middle of a run
      fault_mode = 0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (12) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_status", {busy, done, pass, err_count, fail_addr, fail_data}, 0);
      check("midrst_bus", {ram_bus.address, ram_bus.data_in, ram_bus.write, ram_bus.select}, 0);
      reset = 1'b0;
      done_seen = 0;
      busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done === 1'b1) done_seen++;
         if (busy === 1'b1) busy_seen++;
      end
      check("midrst_no_done", done_seen, 0);
      check("midrst_no_busy", busy_seen, 0);
      run_check("after_rst", 1'b0, 1'b0);

      // start pulses while busy and during DONE are ignored
      run_check("repulse", 1'b1, 1'b1);

      // randomized faults checked against the run model
      for (int k = 0; k < 6; k++) begin
         if (k == 4) begin
            fault_mode = 2; f_const = 8'($urandom_range(0, 255));
         end else begin
            fault_mode = 1;
            f_addr = 3'($urandom_range(0, 7));
            f_bit  = $urandom_range(0, 7);
            f_val  = 1'($urandom_range(0, 1));
         end
         run_check($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
